// File: rtl/if2_fetch_queue.sv
// IF2 fetch queue: pairs in-order imem responses with their issued PCs and buffers
// them for decode, throttling IF1 so allocations never exceed the ring capacity.
module if2_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      current_pc_if1,
    input  logic             req_valid_if1,
    output logic             fetch_allow_if1,
    input  logic             rsp_valid_if2,
    input  logic [31:0]      rsp_instr_if2,
    input  logic             flush_if2,
    output logic             instr_valid_id,
    output logic [31:0]      instr_id,
    output logic [31:0]      pc_id,
    input  logic             instr_ready_id,
    output logic [CNT_W-1:0] occupancy,
    output logic             rsp_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   LIMIT = (CNT_W + 1)'(DEPTH);

    // Pointers carry one extra wrap bit so full (DEPTH) and empty (0) differ;
    // only the low bits index storage, so the ring itself wraps modulo DEPTH.
    logic [CNT_W-1:0] alloc_ptr, fill_ptr, rd_ptr;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] outstanding, filled, stale_total;
    logic [CNT_W:0]   committed;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] alloc_idx, fill_idx, rd_idx;
    logic             accept, keep_rsp, spurious, deq;

    always_comb begin
        outstanding     = alloc_ptr - fill_ptr;
        filled          = fill_ptr - rd_ptr;
        occupancy       = outstanding + filled;
        stale_total     = drop_cnt + outstanding;
        committed       = {1'b0, occupancy} + {1'b0, drop_cnt};
        fetch_allow_if1 = reset_n && !flush_if2 && (committed < LIMIT);

        alloc_idx = alloc_ptr[PTR_W-1:0];
        fill_idx  = fill_ptr[PTR_W-1:0];
        rd_idx    = rd_ptr[PTR_W-1:0];

        accept   = req_valid_if1 && fetch_allow_if1;
        spurious = rsp_valid_if2 && (drop_cnt == '0) && (outstanding == '0);
        keep_rsp = rsp_valid_if2 && !flush_if2 && (drop_cnt == '0) && (outstanding != '0);

        instr_valid_id = (filled != '0) && !flush_if2;
        deq            = instr_valid_id && instr_ready_id;
        instr_id       = instr_valid_id ? instr_mem[rd_idx] : '0;
        pc_id          = instr_valid_id ? pc_mem[rd_idx]    : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            rsp_err   <= 1'b0;
            pc_mem    <= '{default: '0};
            instr_mem <= '{default: '0};
        end else begin
            if (spurious) begin
                rsp_err <= 1'b1;
            end
            if (flush_if2) begin
                // A same-cycle response belongs to the old epoch and retires one stale fetch.
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                rd_ptr    <= '0;
                drop_cnt  <= (rsp_valid_if2 && !spurious) ? stale_total - ONE : stale_total;
            end else begin
                if (accept) begin
                    pc_mem[alloc_idx] <= current_pc_if1;
                    alloc_ptr         <= alloc_ptr + ONE;
                end
                if (rsp_valid_if2 && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - ONE;
                end
                if (keep_rsp) begin
                    instr_mem[fill_idx] <= rsp_instr_if2;
                    fill_ptr            <= fill_ptr + ONE;
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_if2_fetch_queue.sv
// Self-checking bench for if2_fetch_queue: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_if2_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [31:0]      current_pc_if1;
    logic             req_valid_if1;
    logic             fetch_allow_if1;
    logic             rsp_valid_if2;
    logic [31:0]      rsp_instr_if2;
    logic             flush_if2;
    logic             instr_valid_id;
    logic [31:0]      instr_id;
    logic [31:0]      pc_id;
    logic             instr_ready_id;
    logic [CNT_W-1:0] occupancy;
    logic             rsp_err;

    if2_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .current_pc_if1 (current_pc_if1),
        .req_valid_if1  (req_valid_if1),
        .fetch_allow_if1(fetch_allow_if1),
        .rsp_valid_if2  (rsp_valid_if2),
        .rsp_instr_if2  (rsp_instr_if2),
        .flush_if2      (flush_if2),
        .instr_valid_id (instr_valid_id),
        .instr_id       (instr_id),
        .pc_id          (pc_id),
        .instr_ready_id (instr_ready_id),
        .occupancy      (occupancy),
        .rsp_err        (rsp_err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int peak_occ   = 0;

    // Reference model: PCs awaiting a response, completed pairs awaiting decode,
    // count of stale responses owed from before a flush, and the sticky error.
    logic [31:0] pend_q[$];
    logic [31:0] done_pc_q[$];
    logic [31:0] done_in_q[$];
    int          m_drop = 0;
    bit          m_err  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit req, input logic [31:0] pc,
                        input bit rsp, input logic [31:0] ins, input bit fl, input bit rdy);
        int  occ;
        bit  allow, valid;
        @(negedge clk);
        reset_n        = !rst;
        req_valid_if1  = req;
        current_pc_if1 = pc;
        rsp_valid_if2  = rsp;
        rsp_instr_if2  = ins;
        flush_if2      = fl;
        instr_ready_id = rdy;
        #1;
        occ   = pend_q.size() + done_pc_q.size();
        allow = !rst && !fl && (occ + m_drop < DEPTH);
        valid = (done_pc_q.size() > 0) && !fl;
        check("fetch_allow", 32'(fetch_allow_if1), 32'(allow));
        check("instr_valid", 32'(instr_valid_id), 32'(valid));
        check("instr_id",    instr_id, valid ? done_in_q[0] : 32'h0);
        check("pc_id",       pc_id,    valid ? done_pc_q[0] : 32'h0);
        check("occupancy",   32'(occupancy), 32'(occ));
        check("rsp_err",     32'(rsp_err), 32'(m_err));
        if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
        @(posedge clk);
        if (rst) begin
            pend_q.delete(); done_pc_q.delete(); done_in_q.delete();
            m_drop = 0;
            m_err  = 1'b0;
        end else if (fl) begin
            m_drop = m_drop + pend_q.size();
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else m_err = 1'b1;
            end
            pend_q.delete(); done_pc_q.delete(); done_in_q.delete();
        end else begin
            if (valid && rdy) begin
                void'(done_pc_q.pop_front());
                void'(done_in_q.pop_front());
            end
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else if (pend_q.size() > 0) begin
                    done_pc_q.push_back(pend_q.pop_front());
                    done_in_q.push_back(ins);
                end else m_err = 1'b1;
            end
            if (req && allow) pend_q.push_back(pc);
        end
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 32'h0, 0, 32'h0, 0, rdy);
    endtask

    task automatic do_reset();
        step(1, 0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid_if1 = 1'b0; current_pc_if1 = '0;
        rsp_valid_if2 = 1'b0; rsp_instr_if2 = '0; flush_if2 = 1'b0; instr_ready_id = 1'b0;

        // Streaming fill with ready held high
        do_reset();
        peak_occ = 0;
        step(0, 1, 32'h80000000, 0, 32'h0,        0, 1);
        step(0, 1, 32'h80000004, 1, 32'h00000013, 0, 1);
        step(0, 1, 32'h80000008, 1, 32'h00100093, 0, 1);
        step(0, 0, 32'h0,        1, 32'h00200113, 0, 1);
        idle(1); idle(1);
        check("stream_peak_occ", 32'(peak_occ), 32'd2);

        // Backpressure to full, then one dequeue reopens fetch
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 32'h80000000 + 32'(4 * i), 0, 32'h0, 0, 0);
        step(0, 1, 32'h80000010, 0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 32'h00000100 + 32'(i), 0, 0);
        idle(0);
        check("full_occ", 32'(occupancy), 32'd4);
        idle(1);
        idle(0);

        // Flush with two filled and two outstanding
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 32'h80000020 + 32'(4 * i), 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 32'hAAAA0001, 0, 0);
        step(0, 0, 32'h0, 1, 32'hAAAA0002, 0, 0);
        step(0, 0, 32'h0, 0, 32'h0,        1, 1);
        step(0, 1, 32'h80000100, 0, 32'h0, 0, 1);
        step(0, 1, 32'h80000104, 0, 32'h0, 0, 1);
        step(0, 1, 32'h80000108, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 32'hDEAD0001, 0, 1);
        step(0, 0, 32'h0, 1, 32'hDEAD0002, 0, 1);
        step(0, 0, 32'h0, 1, 32'h00500293, 0, 1);
        step(0, 0, 32'h0, 1, 32'h00600313, 0, 1);
        idle(1); idle(1);

        // Flush coincident with the only outstanding response
        do_reset();
        step(0, 1, 32'h80000200, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 32'hBEEF0000, 1, 1);
        idle(1);
        step(0, 1, 32'h80000204, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 32'h00700393, 0, 1);
        idle(1);

        // Spurious response sets a sticky error that survives flush
        do_reset();
        step(0, 0, 32'h0, 1, 32'h12345678, 0, 1);
        idle(1);
        step(0, 0, 32'h0, 0, 32'h0, 1, 1);
        idle(1);
        check("err_sticky", 32'(rsp_err), 32'd1);

        // Reset in the middle of activity
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 32'h80000300 + 32'(4 * i), 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 32'h11110000, 0, 0);
        step(1, 0, 32'h0, 0, 32'h0, 0, 0);
        idle(1);
        step(0, 0, 32'h0, 1, 32'h22220000, 0, 1);
        idle(1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            bit rst_r, fl_r, req_r, rsp_r, rdy_r;
            rst_r = ($urandom_range(0, 199) == 0);
            fl_r  = ($urandom_range(0, 24) == 0);
            req_r = ($urandom_range(0, 9) < 6);
            rdy_r = ($urandom_range(0, 9) < 7);
            if (pend_q.size() + m_drop > 0) rsp_r = ($urandom_range(0, 9) < 6);
            else rsp_r = ($urandom_range(0, 99) < 2);
            step(rst_r, req_r, $urandom, rsp_r, $urandom, fl_r, rdy_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
